// File: rtl/dma_controller_if.sv
// Bus-master side bundle for the DMA controller: device handshake, CPU
// handshake and the shared data-memory write bus (except the tri-state data).
interface dma_controller_if #(
  parameter int unsigned BEAT_IDX_W = 2
);
  logic                  dev_req;
  logic [15:0]           dev_addr;
  logic [BEAT_IDX_W-1:0] dev_beat_sel;
  logic [63:0]           dev_beat_data;
  logic                  dma_begin;
  logic                  cmd;
  logic                  BR;
  logic                  BG;
  logic                  d_writeM;
  logic [15:0]           d_address;
  logic                  dma_end;
  logic                  busy;
  logic                  overrun;

  // DMA controller side
  modport master (
    input  dev_req, dev_addr, dev_beat_data, cmd, BG,
    output dev_beat_sel, dma_begin, BR, d_writeM, d_address, dma_end, busy, overrun
  );

  // Device / CPU / memory side
  modport slave (
    output dev_req, dev_addr, dev_beat_data, cmd, BG,
    input  dev_beat_sel, dma_begin, BR, d_writeM, d_address, dma_end, busy, overrun
  );
endinterface

// File: rtl/dma_controller.sv
// DMA controller: announces a device block to the CPU, waits for the CPU's
// command, acquires the data-memory bus and writes NUM_BEATS beats, each held
// for MEM_LATENCY cycles. Losing the grant parks the transfer and the
// interrupted beat is rewritten in full once the grant returns.
module dma_controller #(
  parameter int unsigned NUM_BEATS   = 3,
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned BEAT_IDX_W  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  dma_controller_if.master bus,
  output logic [63:0] d_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ANNOUNCE = 3'd1;
  localparam logic [2:0] S_WAIT_CMD = 3'd2;
  localparam logic [2:0] S_REQ      = 3'd3;
  localparam logic [2:0] S_XFER     = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam int unsigned CYC_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CYC_W-1:0]      CYC_LAST  = CYC_W'(MEM_LATENCY - 1);
  localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(NUM_BEATS - 1);

  logic [2:0]            state, state_nxt;
  logic [BEAT_IDX_W-1:0] beat, beat_nxt;
  logic [CYC_W-1:0]      cyc, cyc_nxt;
  logic [15:0]           base, base_nxt;

  logic                  begin_r, br_r, wr_r, end_r, busy_r, ovr_r;
  logic [BEAT_IDX_W-1:0] sel_r;
  logic [15:0]           addr_r;

  // Next-state, beat/cycle counters and request latch
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    cyc_nxt   = cyc;
    base_nxt  = base;
    case (state)
      S_IDLE: begin
        if (bus.dev_req) begin
          base_nxt  = bus.dev_addr;
          state_nxt = S_ANNOUNCE;
        end
      end
      S_ANNOUNCE: state_nxt = S_WAIT_CMD;
      S_WAIT_CMD: begin
        if (bus.cmd) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.BG) begin
          state_nxt = S_XFER;
          beat_nxt  = '0;
          cyc_nxt   = '0;
        end
      end
      S_XFER: begin
        // grant loss wins over beat completion: the beat is redone in full
        if (!bus.BG) begin
          state_nxt = S_HOLD;
          cyc_nxt   = '0;
        end else if (cyc == CYC_LAST) begin
          cyc_nxt = '0;
          if (beat == BEAT_LAST) state_nxt = S_DONE;
          else                   beat_nxt  = beat + 1'b1;
        end else begin
          cyc_nxt = cyc + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.BG) state_nxt = S_XFER;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the state being entered
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      beat    <= '0;
      cyc     <= '0;
      base    <= '0;
      begin_r <= 1'b0;
      br_r    <= 1'b0;
      wr_r    <= 1'b0;
      end_r   <= 1'b0;
      busy_r  <= 1'b0;
      ovr_r   <= 1'b0;
      sel_r   <= '0;
      addr_r  <= '0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      cyc     <= cyc_nxt;
      base    <= base_nxt;
      begin_r <= (state_nxt == S_ANNOUNCE);
      br_r    <= (state_nxt == S_REQ) || (state_nxt == S_XFER) || (state_nxt == S_HOLD);
      wr_r    <= (state_nxt == S_XFER);
      end_r   <= (state_nxt == S_DONE);
      busy_r  <= (state_nxt != S_IDLE);
      ovr_r   <= bus.dev_req && (state != S_IDLE);
      if (state_nxt == S_XFER) begin
        sel_r  <= beat_nxt;
        addr_r <= base_nxt + (16'(beat_nxt) << 2);
      end
    end
  end

  assign bus.dma_begin    = begin_r;
  assign bus.BR           = br_r;
  assign bus.d_writeM     = wr_r;
  assign bus.dma_end      = end_r;
  assign bus.busy         = busy_r;
  assign bus.overrun      = ovr_r;
  assign bus.dev_beat_sel = sel_r;
  assign bus.d_address    = addr_r;

  assign d_data = wr_r ? bus.dev_beat_data : 'z;

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: a transaction-level model predicts every output
// each cycle from the stimulus; directed tests add literal address checks.
module tb_dma_controller;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b0;
  wire  [63:0] d_data;

  dma_controller_if #(.BEAT_IDX_W(2)) bus ();

  dma_controller #(.NUM_BEATS(3), .MEM_LATENCY(4), .BEAT_IDX_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.master), .d_data(d_data)
  );

  always #5 Clk = ~Clk;

  logic [63:0] beats [4] = '{64'h1111_2222_3333_4444, 64'hA5A5_0F0F_5A5A_F0F0,
                             64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
  assign bus.dev_beat_data = beats[bus.dev_beat_sel];

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Undriven bus: reads as Z in 4-state simulators, 0 in 2-state ones;
  // beat data is never zero, so a leaked beat is still caught.
  task automatic chk_z(input string name);
    total++;
    if (!(d_data === {64{1'bz}} || d_data === 64'h0)) begin
      bad++;
      $display("FAIL %s actual=%h required=Z t=%0t", name, d_data, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          e_begin, e_br, e_wr, e_end, e_busy, e_ovr, e_rst;
  int unsigned e_sel;
  logic [15:0] e_addr, m_base;
  bit          m_rst;

  task automatic set_exp(input bit busy, input bit br, input bit wr, input bit beg,
                         input bit fin, input int unsigned b);
    e_busy = busy; e_br = br; e_wr = wr; e_begin = beg; e_end = fin;
    e_sel = b; e_addr = m_base + 16'(4 * b); e_rst = 1'b0;
  endtask

  task automatic set_reset();
    e_busy = 0; e_br = 0; e_wr = 0; e_begin = 0; e_end = 0; e_ovr = 0;
    e_sel = 0; e_addr = '0; e_rst = 1'b1;
  endtask

  // Advance one clock; overrun follows from a request arriving while busy.
  task automatic tick();
    @(posedge Clk or posedge Reset);
    if (Reset) begin
      m_rst = 1'b1;
      set_reset();
    end else begin
      e_ovr = bus.dev_req && e_busy;
    end
  endtask

  task automatic model_run();
    int unsigned b, c;
    forever begin
      forever begin
        set_exp(0, 0, 0, 0, 0, 0); tick(); if (m_rst) return;
        if (bus.dev_req) break;
      end
      m_base = bus.dev_addr;
      set_exp(1, 0, 0, 1, 0, 0); tick(); if (m_rst) return;
      forever begin
        set_exp(1, 0, 0, 0, 0, 0); tick(); if (m_rst) return;
        if (bus.cmd) break;
      end
      forever begin
        set_exp(1, 1, 0, 0, 0, 0); tick(); if (m_rst) return;
        if (bus.BG) break;
      end
      b = 0;
      while (b < 3) begin
        c = 0;
        while (c < 4) begin
          set_exp(1, 1, 1, 0, 0, b); tick(); if (m_rst) return;
          if (!bus.BG) begin
            forever begin
              set_exp(1, 1, 0, 0, 0, b); tick(); if (m_rst) return;
              if (bus.BG) break;
            end
            c = 0;
          end else begin
            c++;
          end
        end
        b++;
      end
      set_exp(1, 0, 0, 0, 1, 0); tick(); if (m_rst) return;
    end
  endtask

  initial begin
    m_base = '0;
    set_reset();
    @(posedge Reset);
    forever begin
      m_rst = 1'b0;
      set_reset();
      wait (Reset == 1'b0);
      model_run();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    chk("dma_begin", 64'(bus.dma_begin), 64'(e_begin));
    chk("BR",        64'(bus.BR),        64'(e_br));
    chk("d_writeM",  64'(bus.d_writeM),  64'(e_wr));
    chk("dma_end",   64'(bus.dma_end),   64'(e_end));
    chk("busy",      64'(bus.busy),      64'(e_busy));
    chk("overrun",   64'(bus.overrun),   64'(e_ovr));
    if (e_wr) begin
      chk("d_address", 64'(bus.d_address),    64'(e_addr));
      chk("beat_sel",  64'(bus.dev_beat_sel), 64'(e_sel));
      chk("d_data",    d_data,                beats[e_sel]);
    end else begin
      chk_z("d_data_z");
    end
    if (e_rst) begin
      chk("rst_addr", 64'(bus.d_address),    64'h0);
      chk("rst_sel",  64'(bus.dev_beat_sel), 64'h0);
    end
  end

  // ---------------- activity log ----------------
  logic [15:0] wr_q[$];
  int unsigned n_begin, n_end, n_ovr;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.d_writeM)  wr_q.push_back(bus.d_address);
      if (bus.dma_begin) n_begin++;
      if (bus.dma_end)   n_end++;
      if (bus.overrun)   n_ovr++;
    end
  end

  task automatic clear_log();
    wr_q.delete();
    n_begin = 0; n_end = 0; n_ovr = 0;
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic start_req(input logic [15:0] a);
    bus.dev_addr = a;
    bus.dev_req  = 1'b1;
    cyc(1);
    bus.dev_req  = 1'b0;
    chk("begin_after_req", 64'(bus.dma_begin), 64'h1);
  endtask

  task automatic wait_end(input int unsigned lim);
    int unsigned n = 0;
    while (!bus.dma_end && n < lim) begin
      cyc(1);
      n++;
    end
    chk("dma_end_seen", 64'(bus.dma_end), 64'h1);
    bus.cmd = 1'b0;
    bus.BG  = 1'b0;
    cyc(2);
  endtask

  task automatic wait_writes(input int unsigned want, input string name);
    int unsigned n = 0, k = 0;
    while (n < want && k < 40) begin
      cyc(1);
      k++;
      if (bus.d_writeM) n++;
    end
    chk(name, 64'(n), 64'(want));
  endtask

  task automatic chk_block(input string name, input logic [15:0] a0,
                           input logic [15:0] a1, input logic [15:0] a2);
    logic [15:0] lit [3];
    lit = '{a0, a1, a2};
    chk({name, "_writes"}, 64'(wr_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < wr_q.size(); i++)
      chk({name, "_addr"}, 64'(wr_q[i]), 64'(lit[i / 4]));
    chk({name, "_ends"}, 64'(n_end), 64'd1);
    chk({name, "_begins"}, 64'(n_begin), 64'd1);
  endtask

  task automatic full_run(input logic [15:0] a);
    clear_log();
    start_req(a);
    bus.cmd = 1'b1;
    bus.BG  = 1'b1;
    wait_end(60);
  endtask

  initial begin
    bus.dev_req = 1'b0;
    bus.dev_addr = '0;
    bus.cmd = 1'b0;
    bus.BG = 1'b0;
    #1 Reset = 1'b1;
    #2;
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_BR",   64'(bus.BR),   64'h0);
    chk("reset_addr", 64'(bus.d_address), 64'h0);
    #9 Reset = 1'b0;
    cyc(1);

    // T1 nominal
    full_run(16'h01F4);
    chk_block("t1", 16'h01F4, 16'h01F8, 16'h01FC);

    // T2 grant loss inside beat 1
    clear_log();
    start_req(16'h0100);
    bus.cmd = 1'b1;
    bus.BG  = 1'b1;
    wait_writes(6, "t2_pre_loss");
    bus.BG = 1'b0;
    cyc(2);
    chk("t2_hold_BR", 64'(bus.BR), 64'h1);
    chk("t2_hold_wr", 64'(bus.d_writeM), 64'h0);
    cyc(1);
    bus.BG = 1'b1;
    wait_end(60);
    chk("t2_writes", 64'(wr_q.size()), 64'd14);
    if (wr_q.size() == 14) begin
      chk("t2_redo_beat1", 64'(wr_q[6]),  64'h0104);
      chk("t2_last_beat1", 64'(wr_q[9]),  64'h0104);
      chk("t2_beat2",      64'(wr_q[10]), 64'h0108);
    end
    chk("t2_ends", 64'(n_end), 64'd1);

    // T3 overrun during transfer
    clear_log();
    start_req(16'h0200);
    bus.cmd = 1'b1;
    bus.BG  = 1'b1;
    wait_writes(3, "t3_pre_ovr");
    bus.dev_addr = 16'h0300;
    bus.dev_req  = 1'b1;
    cyc(1);
    bus.dev_req  = 1'b0;
    chk("t3_overrun", 64'(bus.overrun), 64'h1);
    wait_end(60);
    chk_block("t3", 16'h0200, 16'h0204, 16'h0208);
    chk("t3_ovr_count", 64'(n_ovr), 64'd1);

    // T4 asynchronous reset mid-transfer
    clear_log();
    start_req(16'h0400);
    bus.cmd = 1'b1;
    bus.BG  = 1'b1;
    wait_writes(5, "t4_pre_rst");
    #2 Reset = 1'b1;
    #1;
    chk("t4_busy", 64'(bus.busy), 64'h0);
    chk("t4_BR",   64'(bus.BR),   64'h0);
    chk("t4_wr",   64'(bus.d_writeM), 64'h0);
    chk("t4_addr", 64'(bus.d_address), 64'h0);
    chk_z("t4_data_z");
    bus.cmd = 1'b0;
    bus.BG  = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b0;
    cyc(1);
    full_run(16'h01F4);
    chk_block("t4", 16'h01F4, 16'h01F8, 16'h01FC);

    // T5 address wrap
    full_run(16'hFFFC);
    chk_block("t5", 16'hFFFC, 16'h0000, 16'h0004);

    // T6 no authorisation for 50 cycles
    clear_log();
    start_req(16'h0010);
    cyc(50);
    chk("t6_BR_low", 64'(bus.BR),   64'h0);
    chk("t6_busy",   64'(bus.busy), 64'h1);
    chk("t6_nowr",   64'(wr_q.size()), 64'd0);
    bus.cmd = 1'b1;
    cyc(1);
    chk("t6_BR_rise", 64'(bus.BR), 64'h1);
    bus.BG = 1'b1;
    wait_end(60);
    chk_block("t6", 16'h0010, 16'h0014, 16'h0018);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
